param_pipeline: RTL
===================

// Module: param_pipeline
// PURPOSE
//  Parametrised 3-stage ALU pipeline: S1 decode/issue, S2 operand latch + ALU, S3 result/writeback.
//  Generalises data/register/immediate widths, adds valid/ready issue handshake, RAW hazard
//  handling (forwarding or interlock) and a stall counter. Top-level execution core.
// PARAMETERS
//  DATA_W  32  datapath and register width
//  AW      5   register address width; register file holds 2**AW entries
//  IMM_W   12  immediate field width, sign-extended to DATA_W
//  INSTR_W (localparam) 3+1+1+3*AW+IMM_W = 32 at defaults
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        instr_in carries an instruction
//  in_ready     out  1        S1 can accept; transfer when in_valid && in_ready
//  instr_in     in   INSTR_W  {op[2:0], ds, we, ws, rs1, rs2, imm}, MSB first
//  alu_out      out  DATA_W   S3 result register
//  out_valid    out  1        S3 holds a valid instruction
//  out_ws       out  AW       S3 destination register
//  stall_cycles out  32       saturating count of cycles with in_valid && !in_ready
// BEHAVIOUR
//  Reset: all stage valids=0, regfile all 0, alu_out=0, out_valid=0, out_ws=0, stall_cycles=0,
//   in_ready=1 in the cycle after reset. Reset mid-operation drops every in-flight instruction;
//   no writeback on the reset edge.
//  Flow: accepted at edge k -> S1 after k, S2 after k+1, S3 after k+2 (out_valid=1 that cycle);
//   regfile written at edge k+3 when S3 valid && we && ws!=0. Throughput 1/clk when no stall.
//  r0 reads 0; writes to r0 are ignored and never create hazards.
//  Regfile read is combinational on S1 rs1/rs2 and latched into S2 at the S1->S2 edge.
//  ds=1: operand B = sext(imm), rs2 ignored (no hazard on rs2); ds=0: operand B = R[rs2].
//  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed, result 0/1).
//   Add/sub wrap mod 2**DATA_W; shift amount = B[$clog2(DATA_W)-1:0].
//  Hazard: S1 valid, source reg != 0, matches ws of valid S2 or S3 with we=1.
//   Both match -> S2 (younger) is the producer.
//  S1 holds while stalled; S2 receives a bubble; empty S1 never stalls. No output backpressure.
// CONFIGURATION
//  PIPE_FWD_EN defined: hazards resolved by forwarding S2 ALU result / S3 alu_out into the S1
//   operand mux; no stalls ever, in_ready tied to 1, stall_cycles stays 0.
//  PIPE_FWD_EN undefined: interlock; in_ready=0 while hazard, dependent instruction issues to S2
//   only once the producer has written back (max 2 bubbles). Results identical, timing differs.
// STRUCTURE
//  pipe_pkg: ALU op enum, instruction field offset/width constants (functions of AW, IMM_W).
//  Sub-module pipe_alu (combinational, DATA_W param); regfile, stage regs, hazard logic inline.
// TESTING
//  1 Reset then ADDI r1=r0+5, ADDI r2=r0+7 back-to-back -> alu_out 5 then 7 on consecutive cycles.
//  2 ADDI r1=r0+3; ADD r2=r1+r1 immediately -> FWD: r2=6, no bubble; no FWD: 2 bubbles,
//    in_ready low 2 cycles, stall_cycles=2.
//  3 SUB r3=r0-r1 (r1=1) -> 0xFFFFFFFF; SLT r4=r3<r0 -> 1; SRL r5=r3>>31 via imm -> 1.
//  4 Write r0 with imm 9, then ADD r6=r0+r0 -> 0, no stall in either config.
//  5 r1 produced in S2 and S3 by two writes (1 then 2), consumer reads r1 -> uses 2.
//  6 Assert rst with 3 instructions in flight -> out_valid 0 next cycle, no regfile write, all regs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the param_pipeline execution core: ALU opcodes and
// instruction field layout, expressed as functions of the register and immediate widths.
package pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_SLT = 3'd7
    } alu_op_e;

    localparam int OP_W = 3;

    // Layout, MSB first: {op, ds, we, ws, rs1, rs2, imm}
    function automatic int instr_w(input int aw, input int imm_w);
        return OP_W + 2 + 3 * aw + imm_w;
    endfunction

    function automatic int off_rs2(input int imm_w);
        return imm_w;
    endfunction

    function automatic int off_rs1(input int aw, input int imm_w);
        return imm_w + aw;
    endfunction

    function automatic int off_ws(input int aw, input int imm_w);
        return imm_w + 2 * aw;
    endfunction

    function automatic int off_we(input int aw, input int imm_w);
        return imm_w + 3 * aw;
    endfunction

    function automatic int off_ds(input int aw, input int imm_w);
        return imm_w + 3 * aw + 1;
    endfunction

    function automatic int off_op(input int aw, input int imm_w);
        return imm_w + 3 * aw + 2;
    endfunction

endpackage

// File: rtl/param_pipeline_if.sv
// Issue/result bundle of the param_pipeline core; the core is the slave,
// the instruction source and result consumer is the master.
interface param_pipeline_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int IMM_W  = 12
);
    localparam int INSTR_W = pipe_pkg::instr_w(AW, IMM_W);

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_in;
    logic [DATA_W-1:0]  alu_out;
    logic               out_valid;
    logic [AW-1:0]      out_ws;
    logic [31:0]        stall_cycles;

    modport master (
        output in_valid, instr_in,
        input  in_ready, alu_out, out_valid, out_ws, stall_cycles
    );

    modport slave (
        input  in_valid, instr_in,
        output in_ready, alu_out, out_valid, out_ws, stall_cycles
    );
endinterface

// File: rtl/pipe_alu.sv
// Combinational ALU of the S2 stage. Add/sub wrap, shifts use the low
// $clog2(DATA_W) bits of b, SLT is a signed compare returning 0/1.
module pipe_alu
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    localparam int SHW = $clog2(DATA_W);

    always_comb begin
        // NOTE: y gets a default before the case so no path can leave it unassigned and infer a latch.
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[SHW-1:0];
            OP_SRL:  y = a >> b[SHW-1:0];
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/param_pipeline.sv
// 3-stage ALU core: S1 decode/issue, S2 operand latch + ALU, S3 result/writeback.
// Define PIPE_FWD_EN to resolve RAW hazards by forwarding; otherwise S1 interlocks.
module param_pipeline
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int IMM_W  = 12
) (
    input  logic            clk,
    input  logic            rst,
    param_pipeline_if.slave bus
);
    localparam int INSTR_W = instr_w(AW, IMM_W);
    localparam int NREG    = 2 ** AW;
    localparam int O_RS2   = off_rs2(IMM_W);
    localparam int O_RS1   = off_rs1(AW, IMM_W);
    localparam int O_WS    = off_ws(AW, IMM_W);
    localparam int O_WE    = off_we(AW, IMM_W);
    localparam int O_DS    = off_ds(AW, IMM_W);
    localparam int O_OP    = off_op(AW, IMM_W);

    logic [DATA_W-1:0]  regs [NREG];

    logic               s1_valid;
    logic [INSTR_W-1:0] s1_instr;
    alu_op_e            s1_op;
    logic               s1_ds, s1_we;
    logic [AW-1:0]      s1_ws, s1_rs1, s1_rs2;
    logic [IMM_W-1:0]   s1_imm;

    logic               s2_valid, s2_we;
    alu_op_e            s2_op;
    logic [AW-1:0]      s2_ws;
    logic [DATA_W-1:0]  s2_a, s2_b, s2_res;

    logic               s3_valid, s3_we;
    logic [AW-1:0]      s3_ws;
    logic [DATA_W-1:0]  s3_res;

    logic [31:0]        stall_cnt;
    logic               stall;
    logic               rs1_s2, rs1_s3, rs2_s2, rs2_s3;
    logic [DATA_W-1:0]  op_a, src_b, op_b;

    assign s1_op  = alu_op_e'(s1_instr[O_OP +: OP_W]);
    assign s1_ds  = s1_instr[O_DS];
    assign s1_we  = s1_instr[O_WE];
    assign s1_ws  = s1_instr[O_WS +: AW];
    assign s1_rs1 = s1_instr[O_RS1 +: AW];
    assign s1_rs2 = s1_instr[O_RS2 +: AW];
    assign s1_imm = s1_instr[IMM_W-1:0];

    function automatic logic produces(input logic v, input logic we,
                                      input logic [AW-1:0] ws, input logic [AW-1:0] rs);
        return v && we && (rs != '0) && (ws == rs);
    endfunction

    // An immediate-form instruction never depends on rs2.
    assign rs1_s2 = produces(s2_valid, s2_we, s2_ws, s1_rs1);
    assign rs1_s3 = produces(s3_valid, s3_we, s3_ws, s1_rs1);
    assign rs2_s2 = !s1_ds && produces(s2_valid, s2_we, s2_ws, s1_rs2);
    assign rs2_s3 = !s1_ds && produces(s3_valid, s3_we, s3_ws, s1_rs2);

`ifdef PIPE_FWD_EN
    assign stall = 1'b0;
    // S2 is the younger producer, so it wins over S3.
    assign op_a  = rs1_s2 ? s2_res : (rs1_s3 ? s3_res : regs[s1_rs1]);
    assign src_b = rs2_s2 ? s2_res : (rs2_s3 ? s3_res : regs[s1_rs2]);
`else
    assign stall = s1_valid && (rs1_s2 || rs1_s3 || rs2_s2 || rs2_s3);
    assign op_a  = regs[s1_rs1];
    assign src_b = regs[s1_rs2];
`endif

    assign op_b = s1_ds ? {{(DATA_W-IMM_W){s1_imm[IMM_W-1]}}, s1_imm} : src_b;

    pipe_alu #(.DATA_W(DATA_W)) u_alu (
        .op (s2_op),
        .a  (s2_a),
        .b  (s2_b),
        .y  (s2_res)
    );

    // NOTE: stage payload registers are qualified by their valid bits and are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s3_we     <= 1'b0;
            s3_ws     <= '0;
            s3_res    <= '0;
            stall_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before.
            if (!stall) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) s1_instr <= bus.instr_in;
            end
            s2_valid <= s1_valid && !stall;
            if (s1_valid && !stall) begin
                s2_op <= s1_op;
                s2_we <= s1_we;
                s2_ws <= s1_ws;
                s2_a  <= op_a;
                s2_b  <= op_b;
            end
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_we  <= s2_we;
                s3_ws  <= s2_ws;
                s3_res <= s2_res;
            end
            if (bus.in_valid && stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // NOTE: the register file must read as zero after reset, so it is built from flops with a reset loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (s3_valid && s3_we && s3_ws != '0) begin
            regs[s3_ws] <= s3_res;
        end
    end

    assign bus.in_ready     = !stall;
    assign bus.alu_out      = s3_res;
    assign bus.out_valid    = s3_valid;
    assign bus.out_ws       = s3_ws;
    assign bus.stall_cycles = stall_cnt;
endmodule
